// File: rtl/ov7670_capture.sv
// ov7670_capture: samples the OV7670 parallel video bus (VSYNC/HREF/D[7:0]),
// pairs bytes into RGB565 pixels and drives the frame-buffer write port with a
// linear raster address (y*H_PIXELS + x). Single clock domain (camera PCLK).
// Ports:
//   clk, reset        pixel clock, synchronous active-high reset
//   vsync, href, pdata camera bus (vsync high = blanking, href high = byte valid)
//   we, wAddr, wData  buffer write port, one-cycle write pulse per pixel
//   frame_done        one-cycle pulse when a captured frame ends
//   line_err          sticky per frame: bad line length or address overflow
module ov7670_capture #(
  parameter int unsigned H_PIXELS = 320,
  parameter int unsigned V_LINES  = 240,
  parameter int unsigned ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        pdata,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              frame_done,
  output logic              line_err
);

  localparam int unsigned TOTAL      = H_PIXELS * V_LINES;
  localparam int unsigned LINE_BYTES = 2 * H_PIXELS;
  // One extra bit so the address can hold TOTAL itself when saturated.
  localparam int unsigned CNT_W      = ADDR_W + 1;
  localparam int unsigned BC_W       = $clog2(LINE_BYTES + 2) + 1;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                vsync_q, vsync_d;
  logic                href_q, href_d;
  logic                phase_q, phase_d;
  logic [7:0]          hi_q, hi_d;
  logic [CNT_W-1:0]    addr_q, addr_d;
  logic [BC_W-1:0]     bcnt_q, bcnt_d;
  logic                pend_q, pend_d;
  logic [15:0]         pend_data_q, pend_data_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                frame_done_q, frame_done_d;
  logic                line_err_q, line_err_d;

  logic vs_rise_c, vs_fall_c, href_rise_c, href_fall_c;

  // Edge detection against the previous bus sample.
  always_comb begin
    vs_rise_c   = ~vsync_q & vsync;
    vs_fall_c   = vsync_q & ~vsync;
    href_rise_c = ~href_q & href;
    href_fall_c = href_q & ~href;
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d      = state_q;
    vsync_d      = vsync;
    href_d       = href;
    phase_d      = phase_q;
    hi_d         = hi_q;
    addr_d       = addr_q;
    bcnt_d       = bcnt_q;
    pend_d       = 1'b0;
    pend_data_d  = pend_data_q;
    pend_addr_d  = pend_addr_q;
    we_d         = pend_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    frame_done_d = 1'b0;
    line_err_d   = line_err_q;

    // A completed pixel is staged one cycle, then presented on the write port.
    if (pend_q) begin
      waddr_d = pend_addr_q;
      wdata_d = pend_data_q;
    end

    unique case (state_q)
      SYNC: begin
        // Never start mid-frame: wait for the start of vertical blanking.
        if (vs_rise_c) state_d = BLANK;
      end

      BLANK: begin
        if (vs_fall_c) begin
          state_d    = ACTIVE;
          addr_d     = '0;
          phase_d    = 1'b0;
          bcnt_d     = '0;
          line_err_d = 1'b0;
        end
      end

      ACTIVE: begin
        if (vs_rise_c) begin
          // Frame ends here; a half-assembled pixel is discarded.
          state_d      = BLANK;
          frame_done_d = 1'b1;
          phase_d      = 1'b0;
        end else if (href) begin
          if (href_rise_c)  bcnt_d = BC_W'(1);
          else if (!(&bcnt_q)) bcnt_d = BC_W'(bcnt_q + 1'b1);

          if (!phase_q) begin
            hi_d    = pdata;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (addr_q < CNT_W'(TOTAL)) begin
              pend_d      = 1'b1;
              pend_data_d = {hi_q, pdata};
              pend_addr_d = ADDR_W'(addr_q);
              addr_d      = CNT_W'(addr_q + 1'b1);
            end else begin
              // Buffer full: drop the pixel, hold the address, flag the frame.
              line_err_d = 1'b1;
            end
          end
        end else if (href_fall_c) begin
          // Trailing odd byte is dropped; check the finished line's length.
          phase_d = 1'b0;
          if (bcnt_q != BC_W'(LINE_BYTES)) line_err_d = 1'b1;
        end
      end

      default: state_d = SYNC;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SYNC;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      phase_q      <= 1'b0;
      hi_q         <= '0;
      addr_q       <= '0;
      bcnt_q       <= '0;
      pend_q       <= 1'b0;
      pend_data_q  <= '0;
      pend_addr_q  <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      frame_done_q <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      phase_q      <= phase_d;
      hi_q         <= hi_d;
      addr_q       <= addr_d;
      bcnt_q       <= bcnt_d;
      pend_q       <= pend_d;
      pend_data_q  <= pend_data_d;
      pend_addr_q  <= pend_addr_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      frame_done_q <= frame_done_d;
      line_err_q   <= line_err_d;
    end
  end

  assign we         = we_q;
  assign wAddr      = waddr_q;
  assign wData      = wdata_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;

endmodule
